sccb_arbiter: RTL and testbench

Two-port arbiter that shares the single SCCB/I2C write master between the boot-time camera register sequencer (port 0) and the runtime tuning logic (port 1, exposure/gain/white-balance writes). Each port gets a one-entry holding register, so a requester can pulse a write even while the master is busy. The block grants round-robin, drives the master's start/addr/data handshake, and reports per-port completion. A watchdog aborts any transaction the master never accepts or never finishes.

---
 rtl/sccb_arbiter.sv | 153 +++++++++++++++
 tb/tb_sccb_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_arbiter.sv
// Round-robin arbiter sharing one SCCB write master between two requesters,
// with per-port one-entry holding registers and a transaction watchdog.
module sccb_arbiter #(
  parameter int unsigned CLK_F      = 100_000_000,
  parameter int unsigned TIMEOUT_MS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_start,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r0_data,
  output logic       r0_ready,
  output logic       r0_done,
  input  logic       r1_start,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r1_data,
  output logic       r1_ready,
  output logic       r1_done,
  input  logic       m_ready,
  output logic       m_start,
  output logic [7:0] m_addr,
  output logic [7:0] m_data,
  output logic       timeout,
  output logic       err
);

  localparam int unsigned TIMEOUT_CYC = CLK_F / 1000 * TIMEOUT_MS;
  localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACK, BUSY} state_t;

  state_t          state, state_nx;
  logic            pend0, pend0_nx, pend1, pend1_nx;
  logic [7:0]      addr0, addr0_nx, data0, data0_nx;
  logic [7:0]      addr1, addr1_nx, data1, data1_nx;
  logic            last, last_nx, win, win_nx, pick;
  logic [WD_W-1:0] wd, wd_nx;
  logic            m_start_nx, r0_done_nx, r1_done_nx, timeout_nx, err_nx;
  logic [7:0]      m_addr_nx, m_data_nx;

  assign r0_ready = ~pend0;
  assign r1_ready = ~pend1;

  always_comb begin
    state_nx   = state;
    pend0_nx   = pend0;
    pend1_nx   = pend1;
    addr0_nx   = addr0;
    data0_nx   = data0;
    addr1_nx   = addr1;
    data1_nx   = data1;
    last_nx    = last;
    win_nx     = win;
    wd_nx      = wd;
    pick       = ~last;
    m_start_nx = 1'b0;
    m_addr_nx  = m_addr;
    m_data_nx  = m_data;
    r0_done_nx = 1'b0;
    r1_done_nx = 1'b0;
    timeout_nx = 1'b0;
    err_nx     = err;

    if (r0_start && !pend0) begin
      pend0_nx = 1'b1;
      addr0_nx = r0_addr;
      data0_nx = r0_data;
    end
    if (r1_start && !pend1) begin
      pend1_nx = 1'b1;
      addr1_nx = r1_addr;
      data1_nx = r1_data;
    end

    unique case (state)
      IDLE: begin
        if (m_ready && (pend0 || pend1)) begin
          // A lone requester always wins; a tie goes to the port not granted last.
          pick       = (pend0 && pend1) ? ~last : pend1;
          win_nx     = pick;
          m_addr_nx  = pick ? addr1 : addr0;
          m_data_nx  = pick ? data1 : data0;
          m_start_nx = 1'b1;
          wd_nx      = '0;
          state_nx   = ACK;
        end
      end
      ACK, BUSY: begin
        if (state == BUSY && m_ready) begin
          if (win) pend1_nx = 1'b0;
          else     pend0_nx = 1'b0;
          r0_done_nx = ~win;
          r1_done_nx = win;
          last_nx    = win;
          state_nx   = IDLE;
        end else if (wd == WD_LAST) begin
          if (win) pend1_nx = 1'b0;
          else     pend0_nx = 1'b0;
          timeout_nx = 1'b1;
          err_nx     = 1'b1;
          last_nx    = win;
          state_nx   = IDLE;
        end else begin
          wd_nx = wd + 1'b1;
          if (state == ACK && !m_ready) state_nx = BUSY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      addr0   <= '0;
      data0   <= '0;
      addr1   <= '0;
      data1   <= '0;
      last    <= 1'b1;
      win     <= 1'b0;
      wd      <= '0;
      m_start <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
      r0_done <= 1'b0;
      r1_done <= 1'b0;
      timeout <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      pend0   <= pend0_nx;
      pend1   <= pend1_nx;
      addr0   <= addr0_nx;
      data0   <= data0_nx;
      addr1   <= addr1_nx;
      data1   <= data1_nx;
      last    <= last_nx;
      win     <= win_nx;
      wd      <= wd_nx;
      m_start <= m_start_nx;
      m_addr  <= m_addr_nx;
      m_data  <= m_data_nx;
      r0_done <= r0_done_nx;
      r1_done <= r1_done_nx;
      timeout <= timeout_nx;
      err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed bench for sccb_arbiter: a default-parameter instance for arbitration
// and a short-watchdog instance (20 cycles) for the abort path.
module tb_sccb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       r0_start = 0, r1_start = 0, m_ready = 1;
  logic [7:0] r0_addr = 0, r0_data = 0, r1_addr = 0, r1_data = 0;
  logic       r0_ready, r0_done, r1_ready, r1_done, m_start, timeout, err;
  logic [7:0] m_addr, m_data;

  logic       t_r0_start = 0, t_r1_start = 0, t_m_ready = 1;
  logic [7:0] t_r0_addr = 0, t_r0_data = 0, t_r1_addr = 0, t_r1_data = 0;
  logic       t_r0_ready, t_r0_done, t_r1_ready, t_r1_done, t_m_start, t_timeout, t_err;
  logic [7:0] t_m_addr, t_m_data;

  int errors = 0;
  int checks = 0;

  sccb_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_start(r0_start), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ready(r0_ready), .r0_done(r0_done),
    .r1_start(r1_start), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ready(r1_ready), .r1_done(r1_done),
    .m_ready(m_ready), .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
    .timeout(timeout), .err(err)
  );

  sccb_arbiter #(.CLK_F(20_000), .TIMEOUT_MS(1)) dut_t (
    .clk(clk), .rst(rst),
    .r0_start(t_r0_start), .r0_addr(t_r0_addr), .r0_data(t_r0_data), .r0_ready(t_r0_ready), .r0_done(t_r0_done),
    .r1_start(t_r1_start), .r1_addr(t_r1_addr), .r1_data(t_r1_data), .r1_ready(t_r1_ready), .r1_done(t_r1_done),
    .m_ready(t_m_ready), .m_start(t_m_start), .m_addr(t_m_addr), .m_data(t_m_data),
    .timeout(t_timeout), .err(t_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for m_start, checks the issued word, then plays the master:
  // accept, stay busy for 'busy' cycles, finish; checks the per-port done pulse.
  task automatic serve(input int port, input logic [7:0] ea, input logic [7:0] ed,
                       input int busy, input string tag, output int waited);
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      if (m_start) begin
        waited = i;
        break;
      end
      cyc();
    end
    check({tag, "_issued"}, 32'(waited >= 0), 32'd1);
    if (waited < 0) return;
    check({tag, "_addr"}, 32'(m_addr), 32'(ea));
    check({tag, "_data"}, 32'(m_data), 32'(ed));
    m_ready = 1'b0;
    cyc();
    check({tag, "_start_pulse"}, 32'(m_start), 32'd0);
    repeat (busy - 1) cyc();
    m_ready = 1'b1;
    cyc();
    check({tag, "_done0"}, 32'(r0_done), 32'(port == 0));
    check({tag, "_done1"}, 32'(r1_done), 32'(port == 1));
    cyc();
    check({tag, "_done_clr"}, 32'(r0_done | r1_done), 32'd0);
  endtask

  initial begin
    #20000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_ready", 32'({r0_ready, r1_ready}), 32'd3);
    check("rst_flags", 32'({r0_done, r1_done, timeout, err}), 32'd0);

    // Single write, 50-cycle busy master
    r0_addr = 8'h12; r0_data = 8'h80; r0_start = 1'b1;
    cyc();
    r0_start = 1'b0;
    check("single_ready_low", 32'(r0_ready), 32'd0);
    check("single_no_early_start", 32'(m_start), 32'd0);
    serve(0, 8'h12, 8'h80, 50, "single", w);
    check("single_latency", 32'(w), 32'd1);
    check("single_ready_back", 32'(r0_ready), 32'd1);

    // Reset so the last-grant pointer is back at 1, then tie: port 0 first
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    r0_addr = 8'h11; r0_data = 8'h01; r0_start = 1'b1;
    r1_addr = 8'h22; r1_data = 8'h02; r1_start = 1'b1;
    cyc();
    r0_start = 1'b0; r1_start = 1'b0;
    check("tie1_both_captured", 32'({r0_ready, r1_ready}), 32'd0);
    serve(0, 8'h11, 8'h01, 5, "tie1_p0", w);
    serve(1, 8'h22, 8'h02, 5, "tie1_p1", w);
    check("tie1_p1_back_to_back", 32'(w), 32'd0);

    // A lone port-0 write leaves last=0, so the next tie goes to port 1
    r0_addr = 8'h5A; r0_data = 8'hA5; r0_start = 1'b1;
    cyc();
    r0_start = 1'b0;
    serve(0, 8'h5A, 8'hA5, 3, "solo", w);
    r0_addr = 8'h11; r0_data = 8'h01; r0_start = 1'b1;
    r1_addr = 8'h22; r1_data = 8'h02; r1_start = 1'b1;
    cyc();
    r0_start = 1'b0; r1_start = 1'b0;
    serve(1, 8'h22, 8'h02, 5, "tie2_p1", w);
    serve(0, 8'h11, 8'h01, 5, "tie2_p0", w);

    // Capture on port 1 while port 0 is busy; a second port-1 start is dropped
    repeat (3) cyc();
    r0_addr = 8'h33; r0_data = 8'h03; r0_start = 1'b1;
    cyc();
    r0_start = 1'b0;
    cyc();
    check("cap_p0_issued", 32'({m_start, m_addr}), 32'h133);
    m_ready = 1'b0;
    cyc();
    r1_addr = 8'h44; r1_data = 8'h04; r1_start = 1'b1;
    cyc();
    r1_start = 1'b0;
    check("cap_r1_ready_low", 32'(r1_ready), 32'd0);
    cyc();
    r1_addr = 8'h55; r1_data = 8'h05; r1_start = 1'b1;
    cyc();
    r1_start = 1'b0;
    repeat (3) cyc();
    check("cap_no_start_while_busy", 32'(m_start), 32'd0);
    m_ready = 1'b1;
    cyc();
    check("cap_p0_done", 32'(r0_done), 32'd1);
    serve(1, 8'h44, 8'h04, 4, "cap_p1", w);
    check("cap_p1_latency", 32'(w), 32'd1);
    n = 0;
    repeat (10) begin
      n += int'(m_start);
      cyc();
    end
    check("cap_no_second_p1", 32'(n), 32'd0);

    // Watchdog: master never drops m_ready, abort after 20 ACK cycles
    t_r0_addr = 8'h12; t_r0_data = 8'h80; t_r0_start = 1'b1;
    cyc();
    t_r0_start = 1'b0;
    cyc();
    check("to_issued", 32'({t_m_start, t_m_addr, t_m_data}), 32'h11280);
    n = 0;
    repeat (19) begin
      cyc();
      n += int'(t_timeout | t_r0_done);
    end
    check("to_not_early", 32'(n), 32'd0);
    cyc();
    check("to_pulse", 32'(t_timeout), 32'd1);
    check("to_err", 32'(t_err), 32'd1);
    check("to_no_done", 32'(t_r0_done), 32'd0);
    check("to_ready", 32'(t_r0_ready), 32'd1);
    cyc();
    check("to_pulse_clr", 32'(t_timeout), 32'd0);
    t_r0_addr = 8'h21; t_r0_data = 8'h07; t_r0_start = 1'b1;
    cyc();
    t_r0_start = 1'b0;
    cyc();
    check("to_next_issued", 32'({t_m_start, t_m_addr, t_m_data}), 32'h12107);
    t_m_ready = 1'b0;
    repeat (3) cyc();
    t_m_ready = 1'b1;
    cyc();
    check("to_next_done", 32'(t_r0_done), 32'd1);
    check("to_err_sticky", 32'({t_err, t_timeout}), 32'h2);

    // Reset mid-BUSY with both ports pending
    r0_addr = 8'h66; r0_data = 8'h06; r0_start = 1'b1;
    r1_addr = 8'h77; r1_data = 8'h07; r1_start = 1'b1;
    cyc();
    r0_start = 1'b0; r1_start = 1'b0;
    cyc();
    check("rb_issued", 32'({m_start, m_addr}), 32'h166);
    m_ready = 1'b0;
    repeat (2) cyc();
    m_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rb_async_outs", 32'({m_start, m_addr, m_data}), 32'd0);
    check("rb_async_ready", 32'({r0_ready, r1_ready}), 32'd3);
    check("rb_async_t_err", 32'(t_err), 32'd0);
    #1 rst = 1'b0;
    cyc();
    n = 0;
    repeat (10) begin
      n += int'(m_start | r0_done | r1_done);
      cyc();
    end
    check("rb_no_issue_after_rst", 32'(n), 32'd0);
    r1_addr = 8'h88; r1_data = 8'h08; r1_start = 1'b1;
    cyc();
    r1_start = 1'b0;
    serve(1, 8'h88, 8'h08, 3, "rb_new", w);
    check("rb_new_latency", 32'(w), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
